// File: rtl/hwpe_stream_sink_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// hwpe_stream_sink_packer: packs IN_WIDTH beats into strobed OUT_WIDTH words.
// Revision: 1.0
// ----------------------------------------------------------------------------
module hwpe_stream_sink_packer #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 128
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [IN_WIDTH-1:0]    in_data_i,
    input  logic [IN_WIDTH/8-1:0]  in_strb_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [OUT_WIDTH-1:0]   out_data_o,
    output logic [OUT_WIDTH/8-1:0] out_strb_o,
    output logic                   flush_done_o,
    output logic                   busy_o
);

    localparam int unsigned RATIO    = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned CNT_W    = $clog2(RATIO);
    localparam int unsigned IN_STRB  = IN_WIDTH / 8;
    localparam int unsigned OUT_STRB = OUT_WIDTH / 8;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    generate
        if ((IN_WIDTH % 8 != 0) || (OUT_WIDTH % IN_WIDTH != 0) || (RATIO < 2)) begin : g_bad_params
            $error("hwpe_stream_sink_packer: invalid IN_WIDTH/OUT_WIDTH combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state, next_state;
    logic [CNT_W-1:0]      cnt;
    logic [OUT_WIDTH-1:0]  acc_data, full_data;
    logic [OUT_STRB-1:0]   acc_strb, full_strb;
    logic                  out_free, accept, fill_load, flush_load;

    always_comb begin
        out_free   = ~out_valid_o | out_ready_i;
        in_ready_o = (state == FILL) & ~flush_i & ((cnt != LAST_LANE) | out_free);
        accept     = in_valid_i & in_ready_o;
        fill_load  = accept & (cnt == LAST_LANE);
        flush_load = (state == FLUSH) & out_free;
        busy_o     = (cnt != '0) | out_valid_o | (state != FILL);
    end

    // Completing beat bypasses the accumulator straight into the top lane.
    always_comb begin
        full_data = acc_data;
        full_strb = acc_strb;
        full_data[(RATIO-1)*IN_WIDTH +: IN_WIDTH] = in_data_i;
        full_strb[(RATIO-1)*IN_STRB +: IN_STRB]   = in_strb_i;
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL:    if (flush_i) next_state = (cnt != '0) ? FLUSH : DRAIN;
            FLUSH:   if (out_free) next_state = DRAIN;
            DRAIN:   if (out_free) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= FILL;
            cnt          <= '0;
            acc_data     <= '0;
            acc_strb     <= '0;
            out_valid_o  <= 1'b0;
            out_data_o   <= '0;
            out_strb_o   <= '0;
            flush_done_o <= 1'b0;
        end else if (clear_i) begin
            state        <= FILL;
            cnt          <= '0;
            acc_data     <= '0;
            acc_strb     <= '0;
            out_valid_o  <= 1'b0;
            out_data_o   <= '0;
            out_strb_o   <= '0;
            flush_done_o <= 1'b0;
        end else begin
            state        <= next_state;
            flush_done_o <= (state == DRAIN) & out_free;

            // Accumulator is zeroed on every hand-off so unfilled lanes stay 0.
            if (fill_load || flush_load) begin
                cnt      <= '0;
                acc_data <= '0;
                acc_strb <= '0;
            end else if (accept) begin
                acc_data[cnt*IN_WIDTH +: IN_WIDTH] <= in_data_i;
                acc_strb[cnt*IN_STRB +: IN_STRB]   <= in_strb_i;
                cnt <= cnt + CNT_W'(1);
            end

            if (fill_load) begin
                out_valid_o <= 1'b1;
                out_data_o  <= full_data;
                out_strb_o  <= full_strb;
            end else if (flush_load) begin
                out_valid_o <= 1'b1;
                out_data_o  <= acc_data;
                out_strb_o  <= acc_strb;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_sink_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_hwpe_stream_sink_packer: directed self-checking bench for the packer.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_hwpe_stream_sink_packer;

    logic         clk = 1'b0;
    logic         rst_ni, clear, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]  in_data;
    logic [3:0]   in_strb;
    logic [127:0] out_data;
    logic [15:0]  out_strb;
    logic         flush_done, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hwpe_stream_sink_packer #(.IN_WIDTH(32), .OUT_WIDTH(128)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .clear_i     (clear),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_strb_i   (in_strb),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_strb_o  (out_strb),
        .flush_done_o(flush_done),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] s);
        in_valid = 1'b1;
        in_data  = d;
        in_strb  = s;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [127:0] w4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    initial begin
        rst_ni = 1'b0; clear = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_strb = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_strb", out_strb, 0);
        chk("rst_done", flush_done, 0);
        chk("rst_busy", busy, 0);
        rst_ni = 1'b1;
        tick();

        // T1: two full words streamed back to back
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = i; in_strb = 4'hF;
            tick();
            if (i == 2) chk("t1_latency", out_valid, 0);
            if (i == 3) begin
                chk("t1_w0_valid", out_valid, 1);
                chk("t1_w0_data", out_data, w4(0, 1, 2, 3));
                chk("t1_w0_strb", out_strb, 16'hFFFF);
            end
            if (i == 4) chk("t1_w0_gone", out_valid, 0);
            if (i == 7) chk("t1_w1_data", out_data, w4(4, 5, 6, 7));
        end
        in_valid = 1'b0;
        tick();
        chk("t1_idle", out_valid, 0);

        // T2: backpressure after the first word
        for (int i = 0; i < 4; i++) beat(32'h10 + i, 4'hF);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'h14 + i; in_strb = 4'hF;
            #1 chk("t2_ready_lane", in_ready, 1);
            @(posedge clk); #1;
        end
        in_data = 32'h17;
        #1 chk("t2_stall_ready", in_ready, 0);
        tick(); tick();
        chk("t2_hold_data", out_data, w4(32'h10, 32'h11, 32'h12, 32'h13));
        chk("t2_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        #1 chk("t2_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t2_w2_data", out_data, w4(32'h14, 32'h15, 32'h16, 32'h17));
        chk("t2_w2_valid", out_valid, 1);
        tick();
        chk("t2_idle", out_valid, 0);

        // T3: partial flush with delayed output handshake
        beat(32'hA, 4'hF);
        beat(32'hB, 4'hF);
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_busy", busy, 1);
        tick();
        chk("t3_valid", out_valid, 1);
        chk("t3_data", out_data, w4(32'hA, 32'hB, 0, 0));
        chk("t3_strb", out_strb, 16'h00FF);
        tick();
        chk("t3_done_wait", flush_done, 0);
        out_ready = 1'b1;
        tick();
        chk("t3_done", flush_done, 1);
        chk("t3_valid_off", out_valid, 0);
        tick();
        chk("t3_done_pulse", flush_done, 0);
        chk("t3_idle", busy, 0);

        // T4: empty flush
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_no_word", out_valid, 0);
        chk("t4_done_early", flush_done, 0);
        tick();
        chk("t4_done", flush_done, 1);
        tick();
        chk("t4_done_pulse", flush_done, 0);

        // T5: flush beats a simultaneous input beat
        for (int i = 0; i < 3; i++) beat(32'h21 + i, 4'hF);
        in_valid = 1'b1; in_data = 32'h24; in_strb = 4'hF; flush = 1'b1;
        #1 chk("t5_ready", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        tick();
        chk("t5_data", out_data, w4(32'h21, 32'h22, 32'h23, 0));
        chk("t5_strb", out_strb, 16'h0FFF);
        tick();
        chk("t5_done", flush_done, 1);
        // lanes keep their slot even when strobed off
        beat(32'h31, 4'h1); beat(32'h32, 4'h0); beat(32'h33, 4'hF); beat(32'h34, 4'h8);
        chk("t5_next_data", out_data, w4(32'h31, 32'h32, 32'h33, 32'h34));
        chk("t5_next_strb", out_strb, 16'h8F01);
        tick();

        // T6: asynchronous reset, then clear, mid-word
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) beat(32'h41 + i, 4'hF);
        chk("t6_pre_valid", out_valid, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_busy", busy, 0);
        tick();
        rst_ni = 1'b1;
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) beat(32'h51 + i, 4'hF);
        chk("t6_clean_data", out_data, w4(32'h51, 32'h52, 32'h53, 32'h54));
        chk("t6_clean_strb", out_strb, 16'hFFFF);
        beat(32'h61, 4'hF);
        beat(32'h62, 4'hF);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t6_clear_busy", busy, 0);
        chk("t6_clear_data", out_data, 0);
        for (int i = 0; i < 4; i++) beat(32'h71 + i, 4'hF);
        chk("t6_clear_word", out_data, w4(32'h71, 32'h72, 32'h73, 32'h74));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: observed no finish, expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
